// File: rtl/runner_pkg.sv
// Shared sprite-sheet and placement records for the frame painter.
// Coordinate fields are COOR_W bits wide; frame_painter's COOR_WIDTH must match.
package runner_pkg;
  localparam int COOR_W = 11;

  typedef struct packed {
    logic [COOR_W-1:0] x;
    logic [COOR_W-1:0] y;
    logic [COOR_W-1:0] w;
    logic [COOR_W-1:0] h;
  } sprite_t;

  typedef struct packed {
    logic [COOR_W-1:0] x;
    logic [COOR_W-1:0] y;
  } pos_t;
endpackage

// File: rtl/frame_painter_if.sv
// Frame painter control, sprite-sheet read and framebuffer write bus.
// The master side is the painter and the slave side is the surrounding system.
interface frame_painter_if #(parameter int COOR_WIDTH = 11);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic [COOR_WIDTH-1:0] rom_x;
  logic [COOR_WIDTH-1:0] rom_y;
  logic [1:0]            rom_palette;
  logic                  write_en;
  logic [COOR_WIDTH-1:0] write_x;
  logic [COOR_WIDTH-1:0] write_y;
  logic [1:0]            write_palette;

  modport master (input start, rom_palette,
                  output busy, done, rom_x, rom_y, write_en, write_x, write_y, write_palette);
  modport slave  (output start, rom_palette,
                  input busy, done, rom_x, rom_y, write_en, write_x, write_y, write_palette);
endinterface

// File: rtl/frame_painter.sv
// Paints a background raster, then each visible sprite slot in index order.
// Define FRAME_PAINTER_CLIP_EN to suppress element writes that fall off screen.
module frame_painter #(
  parameter int         COOR_WIDTH    = 11,
  parameter int         ELEMENT_COUNT = 32,
  parameter int         SCREEN_W      = 800,
  parameter int         SCREEN_H      = 600,
  parameter logic [1:0] BG_PALETTE    = 2'd0
) (
  input  logic                     clk_33m,
  input  logic                     rst,
  input  logic [ELEMENT_COUNT-1:0] visible,
  input  runner_pkg::sprite_t      sprite [ELEMENT_COUNT],
  input  runner_pkg::pos_t         pos    [ELEMENT_COUNT],
  frame_painter_if.master          bus
);
  localparam int CW = COOR_WIDTH;
  localparam int IW = (ELEMENT_COUNT > 1) ? $clog2(ELEMENT_COUNT) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(ELEMENT_COUNT - 1);
  localparam logic [CW-1:0] BG_XMAX  = CW'(SCREEN_W - 1);
  localparam logic [CW-1:0] BG_YMAX  = CW'(SCREEN_H - 1);

  typedef enum logic [2:0] {IDLE, BG, EL_LOAD, EL_SCAN, EL_DRAIN, DONE} state_t;
  state_t state, state_nx;

  logic [IW-1:0] idx;
  logic [CW-1:0] bx, by;              // next background pixel to issue
  logic [CW-1:0] sx, sy, sw, sh, px, py, u, v;
  logic          wr_vld, wr_bg;
  logic [CW-1:0] wr_x, wr_y;
  logic          bg_emit, bg_last, scan_last, el_skip, on_screen;
  runner_pkg::sprite_t cur_spr;
  runner_pkg::pos_t    cur_pos;
  logic                cur_vis;

  always_comb begin
    cur_spr = sprite[0];
    cur_pos = pos[0];
    cur_vis = visible[0];
    for (int i = 0; i < ELEMENT_COUNT; i++)
      if (idx == IW'(i)) begin
        cur_spr = sprite[i];
        cur_pos = pos[i];
        cur_vis = visible[i];
      end
  end

  assign bg_emit   = (state == BG) || (state == IDLE && bus.start);
  assign bg_last   = (bx == BG_XMAX) && (by == BG_YMAX);
  assign scan_last = (u == sw - CW'(1)) && (v == sh - CW'(1));
  assign el_skip   = !cur_vis || (cur_spr.w == '0) || (cur_spr.h == '0);

  always_ff @(posedge clk_33m) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (bus.start) state_nx = bg_last ? EL_LOAD : BG;
      BG:       if (bg_last) state_nx = EL_LOAD;
      EL_LOAD:  if (!el_skip)               state_nx = EL_SCAN;
                else if (idx == LAST_IDX)   state_nx = DONE;
      EL_SCAN:  if (scan_last) state_nx = EL_DRAIN;
      EL_DRAIN: state_nx = (idx == LAST_IDX) ? DONE : EL_LOAD;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Writes are registered one cycle behind their issue, so the final
  // background pixel is still on the bus during the first EL_LOAD cycle.
  always_ff @(posedge clk_33m) begin
    if (rst) begin
      idx <= '0; bx <= '0; by <= '0;
      sx <= '0; sy <= '0; sw <= '0; sh <= '0; px <= '0; py <= '0; u <= '0; v <= '0;
      wr_vld <= 1'b0; wr_bg <= 1'b0; wr_x <= '0; wr_y <= '0;
    end else begin
      if (bg_emit) begin
        wr_vld <= 1'b1;
        wr_bg  <= 1'b1;
        wr_x   <= bx;
        wr_y   <= by;
        idx    <= '0;
        if (bx == BG_XMAX) begin
          bx <= '0;
          by <= (by == BG_YMAX) ? '0 : by + CW'(1);
        end else begin
          bx <= bx + CW'(1);
        end
      end
      case (state)
        EL_LOAD: begin
          wr_vld <= 1'b0;
          sx <= cur_spr.x; sy <= cur_spr.y; sw <= cur_spr.w; sh <= cur_spr.h;
          px <= cur_pos.x; py <= cur_pos.y;
          u  <= '0;        v  <= '0;
          if (el_skip && idx != LAST_IDX) idx <= idx + IW'(1);
        end
        EL_SCAN: begin
          wr_vld <= 1'b1;
          wr_bg  <= 1'b0;
          wr_x   <= px + u;
          wr_y   <= py + v;
          if (u == sw - CW'(1)) begin
            u <= '0;
            v <= v + CW'(1);
          end else begin
            u <= u + CW'(1);
          end
        end
        EL_DRAIN: begin
          wr_vld <= 1'b0;
          if (idx != LAST_IDX) idx <= idx + IW'(1);
        end
        DONE: begin
          wr_vld <= 1'b0;
          idx    <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef FRAME_PAINTER_CLIP_EN
  assign on_screen = ({1'b0, wr_x} < (CW+1)'(SCREEN_W)) && ({1'b0, wr_y} < (CW+1)'(SCREEN_H));
`else
  assign on_screen = 1'b1;
`endif

  assign bus.rom_x         = (state == EL_SCAN) ? sx + u : '0;
  assign bus.rom_y         = (state == EL_SCAN) ? sy + v : '0;
  assign bus.write_en      = wr_vld && (wr_bg || (bus.rom_palette != 2'd0 && on_screen));
  assign bus.write_x       = wr_x;
  assign bus.write_y       = wr_y;
  assign bus.write_palette = !wr_vld ? 2'd0 : (wr_bg ? BG_PALETTE : bus.rom_palette);
  assign bus.busy          = (state != IDLE);
  assign bus.done          = (state == DONE);
endmodule
